alu_issue_sched: RTL and testbench
==================================

Name: alu_issue_sched

Overview:
- Sequences and arbitrates the shared 8051 ALU between two requesters.
- Requester 0 is the instruction execute path (ACC/B arithmetic). Requester 1 is the address/branch unit (relative-offset and compare arithmetic).
- Accepts one operation at a time over a valid/ready handshake, latches operands, and drives the combinational ALU for one cycle, or for several cycles on MUL/DIV.
- Captures the ALU result and PSW and returns them with a one-cycle done pulse tagged with the owner.

Parameters:
- OP_MUL, 5'b01100, alu_op code treated as multi-cycle multiply.
- OP_DIV, 5'b01101, alu_op code treated as multi-cycle divide.
- MULDIV_CYCLES, 4, total cycles the ALU is held for MUL/DIV (legal range 1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight/pending operation (pipeline flush on branch/interrupt)
- req0_valid  in  1  requester 0 has an operation
- req0_op  in  5  requester 0 ALU function select
- req0_a  in  8  requester 0 operand A
- req0_b  in  8  requester 0 operand B
- req0_psw  in  8  requester 0 PSW input
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req1_valid/req1_op/req1_a/req1_b/req1_psw  in  1/5/8/8/8  same for requester 1
- req1_ready  out  1  as req0_ready
- alu_en  out  1  ALU enable
- alu_op  out  5  ALU function select
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_psw  out  8  ALU PSW input
- alu_ans  in  8  ALU result (combinational)
- alu_psw_nxt  in  8  ALU next PSW (combinational)
- done  out  1  one-cycle result-valid pulse
- done_id  out  1  owner of result (0/1)
- ans  out  8  captured result
- psw_out  out  8  captured PSW
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at edge) puts the block in IDLE with last_grant=1.
- Reset values: all outputs 0, except req*_ready, which follows the IDLE rule (combinational).
- Reset mid-operation discards the op; no done is produced.
- States: IDLE, EXEC, HOLD, DONE. hold_cnt is 4 bits.
- Arbitration in IDLE is round-robin:
  - only one valid: that requester wins.
  - both valid: the requester that is not last_grant wins.
  - reqN_ready = (state==IDLE) & !flush & winner==N. At most one ready is high per cycle.
- Accept (valid&ready at edge):
  - latch op/a/b/psw and owner id; set last_grant=id; go to EXEC.
  - Requesters hold inputs stable until accepted. Deasserting valid before accept is allowed.
- EXEC and HOLD:
  - alu_en=1; alu_op/a/b/psw driven from the latched operands.
  - In IDLE/DONE, alu_en=0 and ALU buses are 0.
- EXEC transitions:
  - if op is neither OP_MUL nor OP_DIV, or MULDIV_CYCLES==1: capture ans<=alu_ans, psw_out<=alu_psw_nxt; go to DONE.
  - else load hold_cnt=MULDIV_CYCLES-2 and go to HOLD.
- HOLD: if hold_cnt==0, capture and go to DONE; else decrement.
- DONE:
  - done=1 and done_id=owner for exactly this cycle.
  - ans/psw_out are valid from this cycle and hold until the next capture.
  - Next state is IDLE.
- Latency from accept edge: single-cycle op gives done 2 cycles later; MUL/DIV gives done MULDIV_CYCLES+1 cycles later.
- Throughput: one single-cycle op per 3 cycles. Back-to-back from the same requester needs valid held through DONE.
- flush=1 at an edge:
  - in EXEC or HOLD: go to IDLE; no capture; ans/psw_out keep their old values; no done.
  - in DONE: the done pulse already visible that cycle stands; go to IDLE.
  - in IDLE: suppresses ready, so no accept occurs.
  - last_grant is unchanged by a flush.
- rst has priority over flush; flush has priority over accept.
- alu_op values other than OP_MUL/OP_DIV are passed through unchecked.

Test Plan:
- Single op: req0 ADD (op 5'b00001) a=8'h3A b=8'h05 -> req0_ready high in IDLE; alu_en high 1 cycle; done 2 cycles after accept with done_id=0, ans=bench ALU model result, busy low the cycle after done.
- Round-robin: req0 and req1 valid continuously after reset -> grants go 0,1,0,1; each done_id matches; no cycle has both readys high.
- MUL with MULDIV_CYCLES=4: req1 op=OP_MUL a=8'h12 b=8'h10 -> alu_en high 4 consecutive cycles with stable operands; done 5 cycles after accept, done_id=1, ans=8'h20 (low byte), psw_out=alu_psw_nxt at the final HOLD cycle.
- Flush in HOLD during DIV: flush on the 2nd ALU cycle -> IDLE next cycle, no done, ans/psw_out keep prior values, next req accepted normally.
- Sync reset mid-EXEC: rst for 1 cycle -> all outputs 0 at next edge, no done; after release, requester 0 wins a tie (last_grant=1).
- MULDIV_CYCLES=1 build: OP_DIV completes like a single-cycle op (done 2 cycles after accept).

Source files
------------

// File: rtl/alu_issue_sched_if.sv
// rtl/alu_issue_sched_if.sv - requester, ALU and result signals of the ALU issue scheduler
interface alu_issue_sched_if;
    logic       flush;

    logic       req0_valid;
    logic [4:0] req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [7:0] req0_psw;
    logic       req0_ready;

    logic       req1_valid;
    logic [4:0] req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [7:0] req1_psw;
    logic       req1_ready;

    logic       alu_en;
    logic [4:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_psw;
    logic [7:0] alu_ans;
    logic [7:0] alu_psw_nxt;

    logic       done;
    logic       done_id;
    logic [7:0] ans;
    logic [7:0] psw_out;
    logic       busy;

    modport master (
        output flush,
        output req0_valid, req0_op, req0_a, req0_b, req0_psw,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_psw,
        input  req1_ready,
        input  alu_en, alu_op, alu_a, alu_b, alu_psw,
        output alu_ans, alu_psw_nxt,
        input  done, done_id, ans, psw_out, busy
    );

    modport slave (
        input  flush,
        input  req0_valid, req0_op, req0_a, req0_b, req0_psw,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_psw,
        output req1_ready,
        output alu_en, alu_op, alu_a, alu_b, alu_psw,
        input  alu_ans, alu_psw_nxt,
        output done, done_id, ans, psw_out, busy
    );
endinterface

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - round-robin issue of two requesters onto the shared 8051 ALU
module alu_issue_sched #(
    parameter logic [4:0] OP_MUL        = 5'b01100,
    parameter logic [4:0] OP_DIV        = 5'b01101,
    parameter int         MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // EXEC already accounts for one ALU cycle, the final HOLD cycle for another
    localparam bit         MULTI_OK  = (MULDIV_CYCLES >= 2);
    localparam logic [3:0] HOLD_INIT = MULTI_OK ? 4'(MULDIV_CYCLES - 2) : 4'd0;

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic [4:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] psw_q;
    logic [3:0] hold_cnt;
    logic [7:0] ans_q;
    logic [7:0] psw_out_q;

    logic       idle;
    logic       in_alu;
    logic       winner;
    logic       ready0;
    logic       ready1;
    logic       accept;
    logic       is_multi;
    logic [4:0] win_op;
    logic [7:0] win_a;
    logic [7:0] win_b;
    logic [7:0] win_psw;

    always_comb begin
        idle   = (state == ST_IDLE);
        in_alu = (state == ST_EXEC) || (state == ST_HOLD);

        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end else if (bus.req0_valid) begin
            winner = 1'b0;
        end else begin
            winner = ~last_grant;
        end

        ready0 = idle && !bus.flush && !winner;
        ready1 = idle && !bus.flush && winner;
        accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);

        win_op  = winner ? bus.req1_op  : bus.req0_op;
        win_a   = winner ? bus.req1_a   : bus.req0_a;
        win_b   = winner ? bus.req1_b   : bus.req0_b;
        win_psw = winner ? bus.req1_psw : bus.req0_psw;

        is_multi = MULTI_OK && ((op_q == OP_MUL) || (op_q == OP_DIV));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            psw_q      <= '0;
            hold_cnt   <= '0;
            ans_q      <= '0;
            psw_out_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= win_op;
                        a_q        <= win_a;
                        b_q        <= win_b;
                        psw_q      <= win_psw;
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (!is_multi) begin
                        ans_q     <= bus.alu_ans;
                        psw_out_q <= bus.alu_psw_nxt;
                        state     <= ST_DONE;
                    end else begin
                        hold_cnt <= HOLD_INIT;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (hold_cnt == 4'd0) begin
                        ans_q     <= bus.alu_ans;
                        psw_out_q <= bus.alu_psw_nxt;
                        state     <= ST_DONE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign bus.alu_en  = in_alu;
    assign bus.alu_op  = in_alu ? op_q  : 5'd0;
    assign bus.alu_a   = in_alu ? a_q   : 8'd0;
    assign bus.alu_b   = in_alu ? b_q   : 8'd0;
    assign bus.alu_psw = in_alu ? psw_q : 8'd0;

    assign bus.done    = (state == ST_DONE);
    assign bus.done_id = (state == ST_DONE) && owner;
    assign bus.ans     = ans_q;
    assign bus.psw_out = psw_out_q;
    assign bus.busy    = !idle;
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - bench for alu_issue_sched with a transaction-level model
module tb_alu_issue_sched;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;
    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    alu_issue_sched_if bus ();
    alu_issue_sched_if bus1 ();

    alu_issue_sched #(.MULDIV_CYCLES(MD)) dut  (.clk(clk), .rst(rst), .bus(bus));
    alu_issue_sched #(.MULDIV_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Stand-in ALU; PSW mixes in the cycle number so the capture cycle is observable
    function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] psw,
                                          input logic [31:0] c);
        logic [15:0] p;
        logic [8:0]  s;
        logic [7:0]  r;
        logic [7:0]  f;
        p = '0;
        s = '0;
        r = '0;
        f = psw;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; f[7] = s[8]; end
            OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; f[7] = s[8]; end
            OP_MUL: begin p = a * b; r = p[7:0]; f[2] = |p[15:8]; end
            OP_DIV: begin r = (b == 8'd0) ? 8'hFF : a / b; f[2] = (b == 8'd0); end
            default: r = a ^ b;
        endcase
        f = f ^ {5'b0, c[2:0]};
        return {r, f};
    endfunction

    assign {bus.alu_ans, bus.alu_psw_nxt}   = alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_psw, cyc);
    assign {bus1.alu_ans, bus1.alu_psw_nxt} = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_psw, cyc);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one in-flight transaction tracked by its age in cycles since accept
    bit         chk_en = 1'b0;
    logic       m_busy = 1'b0;
    int         m_age  = 0;
    int         m_len  = 1;
    logic       m_owner = 1'b0;
    logic       m_lg    = 1'b1;
    logic [4:0] m_op    = '0;
    logic [7:0] m_a = '0, m_b = '0, m_psw = '0, m_ans = '0, m_pout = '0;
    logic       e_en, e_done, m_w;

    int         acc_n = 0, done_n = 0, acc_cyc = 0, done_cyc = 0;
    logic       acc_id = 1'b0;
    int         done_ids[$];
    int         en_run = 0, last_run = 0;
    logic [7:0] last_psw_nxt = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            e_en   = m_busy && (m_age <= m_len);
            e_done = m_busy && (m_age == m_len + 1);
            check("busy",    bus.busy,    m_busy);
            check("alu_en",  bus.alu_en,  e_en);
            check("alu_op",  bus.alu_op,  e_en ? m_op  : 5'd0);
            check("alu_a",   bus.alu_a,   e_en ? m_a   : 8'd0);
            check("alu_b",   bus.alu_b,   e_en ? m_b   : 8'd0);
            check("alu_psw", bus.alu_psw, e_en ? m_psw : 8'd0);
            check("done",    bus.done,    e_done);
            check("done_id", bus.done_id, e_done && m_owner);
            check("ans",     bus.ans,     m_ans);
            check("psw_out", bus.psw_out, m_pout);
            check("ready_both", bus.req0_ready && bus.req1_ready, 1'b0);
            if (m_busy || bus.flush) begin
                check("ready0_off", bus.req0_ready, 1'b0);
                check("ready1_off", bus.req1_ready, 1'b0);
            end else if (bus.req0_valid || bus.req1_valid) begin
                m_w = (bus.req0_valid && bus.req1_valid) ? !m_lg : bus.req1_valid;
                check("ready0", bus.req0_ready, !m_w);
                check("ready1", bus.req1_ready, m_w);
            end

            if (!rst && ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))) begin
                acc_n++;
                acc_cyc = cyc;
                acc_id  = bus.req1_valid && bus.req1_ready;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
                done_ids.push_back(int'(bus.done_id));
            end
            if (bus.alu_en) begin
                en_run++;
                last_psw_nxt = bus.alu_psw_nxt;
            end else if (en_run > 0) begin
                last_run = en_run;
                en_run   = 0;
            end
        end

        if (rst) begin
            m_busy = 1'b0; m_lg = 1'b1; m_ans = '0; m_pout = '0; m_age = 0;
        end else if (m_busy) begin
            if (m_age > m_len || bus.flush) begin
                m_busy = 1'b0;
            end else begin
                if (m_age == m_len) {m_ans, m_pout} = alu_f(m_op, m_a, m_b, m_psw, cyc);
                m_age++;
            end
        end else if (!bus.flush && (bus.req0_valid || bus.req1_valid)) begin
            m_w     = (bus.req0_valid && bus.req1_valid) ? !m_lg : bus.req1_valid;
            m_op    = m_w ? bus.req1_op  : bus.req0_op;
            m_a     = m_w ? bus.req1_a   : bus.req0_a;
            m_b     = m_w ? bus.req1_b   : bus.req0_b;
            m_psw   = m_w ? bus.req1_psw : bus.req0_psw;
            m_owner = m_w;
            m_lg    = m_w;
            m_busy  = 1'b1;
            m_age   = 1;
            m_len   = (m_op == OP_MUL || m_op == OP_DIV) ? MD : 1;
        end
        if (rst) chk_en = 1'b1;
    end

    task automatic wait_acc(input int target, input string nm);
        for (int i = 0; i < 60 && acc_n < target; i++) @(posedge clk);
        check({nm, "_accept"}, acc_n >= target, 1'b1);
        #1;
    endtask

    task automatic wait_done(input int target, input string nm);
        for (int i = 0; i < 80 && done_n < target; i++) @(posedge clk);
        check({nm, "_done_seen"}, done_n >= target, 1'b1);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [4:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] psw);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_psw = psw; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_psw = psw; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    int a0, d0, t_acc, t_done, en_cnt;
    logic       did;
    logic [7:0] a1;

    initial begin
        bus.flush = 1'b0;  bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = '0;  bus.req0_a = '0; bus.req0_b = '0; bus.req0_psw = '0;
        bus.req1_op = '0;  bus.req1_a = '0; bus.req1_b = '0; bus.req1_psw = '0;
        bus1.flush = 1'b0; bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
        bus1.req0_op = '0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_psw = '0;
        bus1.req1_op = '0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_psw = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ans", bus.ans, 8'h00);
        check("rst_psw_out", bus.psw_out, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);

        // single-cycle ADD from requester 0
        set_req(1'b0, OP_ADD, 8'h3A, 8'h05, 8'h00);
        @(negedge clk);
        check("t1_ready0", bus.req0_ready, 1'b1);
        check("t1_ready1", bus.req1_ready, 1'b0);
        a0 = acc_n; d0 = done_n;
        wait_acc(a0 + 1, "t1");
        bus.req0_valid = 1'b0;
        wait_done(d0 + 1, "t1");
        check("t1_latency", done_cyc - acc_cyc, 2);
        check("t1_done_id", done_ids[d0], 0);
        check("t1_ans", bus.ans, 8'h3F);
        check("t1_busy_after", bus.busy, 1'b0);
        check("t1_en_len", last_run, 1);

        // round robin with both requesters held valid
        pulse_rst();
        set_req(1'b0, OP_ADD, 8'h10, 8'h20, 8'h00);
        set_req(1'b1, OP_SUB, 8'h30, 8'h08, 8'h80);
        a0 = acc_n; d0 = done_n;
        wait_acc(a0 + 4, "rr");
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_done(d0 + 4, "rr");
        for (int i = 0; i < 4; i++) check("rr_grant", done_ids[d0 + i], i % 2);
        check("rr_ans_last", bus.ans, 8'h28);

        // MUL on requester 1
        set_req(1'b1, OP_MUL, 8'h12, 8'h10, 8'h00);
        a0 = acc_n; d0 = done_n;
        wait_acc(a0 + 1, "mul");
        bus.req1_valid = 1'b0;
        wait_done(d0 + 1, "mul");
        check("mul_latency", done_cyc - acc_cyc, MD + 1);
        check("mul_done_id", done_ids[d0], 1);
        check("mul_ans", bus.ans, 8'h20);
        check("mul_psw", bus.psw_out, last_psw_nxt);
        check("mul_en_len", last_run, MD);

        // DIV flushed on its second ALU cycle
        check("pre_flush_ans", bus.ans, 8'h20);
        set_req(1'b0, OP_DIV, 8'h64, 8'h07, 8'h00);
        a0 = acc_n; d0 = done_n;
        wait_acc(a0 + 1, "div");
        bus.req0_valid = 1'b0;
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_alu_en", bus.alu_en, 1'b0);
        check("flush_ans", bus.ans, 8'h20);
        repeat (6) @(posedge clk);
        #1 check("flush_no_done", done_n, d0);
        set_req(1'b1, OP_SUB, 8'h50, 8'h10, 8'h00);
        a0 = acc_n;
        wait_acc(a0 + 1, "post_flush");
        bus.req1_valid = 1'b0;
        wait_done(d0 + 1, "post_flush");
        check("post_flush_ans", bus.ans, 8'h40);
        check("post_flush_id", done_ids[d0], 1);
        check("post_flush_latency", done_cyc - acc_cyc, 2);

        // sync reset while in EXEC
        set_req(1'b1, OP_ADD, 8'h01, 8'h02, 8'h00);
        a0 = acc_n; d0 = done_n;
        wait_acc(a0 + 1, "rstx");
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rstx_busy", bus.busy, 1'b0);
        check("rstx_ans", bus.ans, 8'h00);
        check("rstx_psw", bus.psw_out, 8'h00);
        check("rstx_en", bus.alu_en, 1'b0);
        check("rstx_done", bus.done, 1'b0);
        set_req(1'b0, OP_ADD, 8'h11, 8'h22, 8'h00);
        set_req(1'b1, OP_ADD, 8'h33, 8'h44, 8'h00);
        a0 = acc_n;
        wait_acc(a0 + 1, "rstx_tie");
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("rstx_tie_winner", acc_id, 1'b0);
        wait_done(d0 + 1, "rstx_tie");
        check("rstx_one_done", done_n, d0 + 1);
        check("rstx_tie_ans", bus.ans, 8'h33);

        // single-cycle MUL/DIV build
        bus1.req0_op = OP_DIV; bus1.req0_a = 8'h64; bus1.req0_b = 8'h07; bus1.req0_psw = 8'h00;
        bus1.req0_valid = 1'b1;
        t_acc = -1; t_done = -1; en_cnt = 0; did = 1'b1; a1 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.req0_valid && bus1.req0_ready) t_acc = i;
            if (bus1.alu_en) en_cnt++;
            if (bus1.done) begin t_done = i; did = bus1.done_id; a1 = bus1.ans; end
            @(posedge clk); #1;
            if (t_acc >= 0) bus1.req0_valid = 1'b0;
        end
        check("md1_latency", t_done - t_acc, 2);
        check("md1_done_id", did, 1'b0);
        check("md1_ans", a1, 8'h0E);
        check("md1_en_len", en_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
